// File: rtl/slurm16_memory_arbiter_if.sv
// slurm16_memory_arbiter_if: requester, response and SRAM port signals of the memory arbiter.
interface slurm16_memory_arbiter_if #(
    parameter int ADDRESS_BITS = 15
);
    logic                    instruction_request;
    logic [ADDRESS_BITS-1:0] instruction_address;
    logic                    instruction_valid;
    logic [15:0]             instruction_in;
    logic [ADDRESS_BITS-1:0] instruction_address_in;
    logic                    load_memory;
    logic                    store_memory;
    logic [ADDRESS_BITS-1:0] load_store_address;
    logic [15:0]             memory_out;
    logic [1:0]              memory_mask;
    logic                    memory_request_successful;
    logic [15:0]             memory_in;
    logic                    dma_request;
    logic                    dma_write;
    logic [ADDRESS_BITS-1:0] dma_address;
    logic [15:0]             dma_wr_data;
    logic                    dma_ack;
    logic                    dma_rd_valid;
    logic [15:0]             dma_rd_data;
    logic [ADDRESS_BITS-1:0] mem_address;
    logic [15:0]             mem_wr_data;
    logic [1:0]              mem_wr_mask;
    logic                    mem_rd;
    logic                    mem_wr;
    logic [15:0]             mem_rd_data;

    modport slave (
        input  instruction_request, instruction_address, load_memory, store_memory,
               load_store_address, memory_out, memory_mask, dma_request, dma_write,
               dma_address, dma_wr_data, mem_rd_data,
        output instruction_valid, instruction_in, instruction_address_in,
               memory_request_successful, memory_in, dma_ack, dma_rd_valid, dma_rd_data,
               mem_address, mem_wr_data, mem_wr_mask, mem_rd, mem_wr
    );

    modport master (
        output instruction_request, instruction_address, load_memory, store_memory,
               load_store_address, memory_out, memory_mask, dma_request, dma_write,
               dma_address, dma_wr_data, mem_rd_data,
        input  instruction_valid, instruction_in, instruction_address_in,
               memory_request_successful, memory_in, dma_ack, dma_rd_valid, dma_rd_data,
               mem_address, mem_wr_data, mem_wr_mask, mem_rd, mem_wr
    );
endinterface

// File: rtl/slurm16_memory_arbiter.sv
// slurm16_memory_arbiter: shares one single-cycle SRAM port between fetch, load/store and DMA.
module slurm16_memory_arbiter #(
    parameter int ADDRESS_BITS   = 15,
    parameter int DMA_BURST_MAX  = 8,
    parameter int DMA_STARVE_MAX = 4
) (
    input logic                     CLK,
    input logic                     RSTb,
    slurm16_memory_arbiter_if.slave bus
);
    localparam int BW = $clog2(DMA_BURST_MAX + 1);
    localparam int SW = $clog2(DMA_STARVE_MAX + 1);

    typedef enum logic {ARB_CPU, ARB_DMA} state_t;
    typedef enum logic [1:0] {RSP_NONE, RSP_FETCH, RSP_DATA, RSP_DMA} rsp_t;

    state_t                  state_q, state_d;
    rsp_t                    rsp_q, rsp_d;
    logic [BW-1:0]           burst_q, burst_d, beat;
    logic [SW-1:0]           starve_q, starve_d;
    logic [ADDRESS_BITS-1:0] iaddr_q, iaddr_d, addr;
    logic                    data_req, g_burst, g_data, g_starve, g_fetch, g_dma, d_wr, dma_wr;

    assign data_req = bus.load_memory || bus.store_memory;
    assign g_burst  = state_q == ARB_DMA && bus.dma_request;
    assign g_data   = !g_burst && data_req;
    assign g_starve = !g_burst && !data_req && bus.dma_request && starve_q == SW'(DMA_STARVE_MAX);
    assign g_fetch  = !g_burst && !data_req && !g_starve && bus.instruction_request;
    assign g_dma    = g_burst || g_starve || (!data_req && !bus.instruction_request && bus.dma_request);
    assign d_wr     = g_data && bus.store_memory;
    assign dma_wr   = g_dma && bus.dma_write;

    // beat is the burst length including the beat granted this cycle
    assign beat     = state_q == ARB_DMA ? burst_q + BW'(1) : BW'(1);
    assign state_d  = (g_dma && beat < BW'(DMA_BURST_MAX)) ? ARB_DMA : ARB_CPU;
    assign burst_d  = state_d == ARB_DMA ? beat : '0;
    assign starve_d = (bus.dma_request && !g_dma)
                      ? (starve_q == SW'(DMA_STARVE_MAX) ? starve_q : starve_q + SW'(1)) : '0;
    assign rsp_d    = g_fetch ? RSP_FETCH : (g_data && !bus.store_memory) ? RSP_DATA
                      : (g_dma && !bus.dma_write) ? RSP_DMA : RSP_NONE;
    assign iaddr_d  = g_fetch ? bus.instruction_address : iaddr_q;
    assign addr     = g_data ? bus.load_store_address : g_dma ? bus.dma_address : bus.instruction_address;

    assign bus.mem_address               = addr;
    assign bus.mem_wr_data               = g_dma ? bus.dma_wr_data : bus.memory_out;
    assign bus.mem_wr_mask               = d_wr ? bus.memory_mask : dma_wr ? 2'b11 : 2'b00;
    assign bus.mem_wr                    = d_wr || dma_wr;
    assign bus.mem_rd                    = g_fetch || (g_data && !bus.store_memory) || (g_dma && !bus.dma_write);
    assign bus.memory_request_successful = g_data;
    assign bus.dma_ack                   = g_dma;
    assign bus.instruction_valid         = rsp_q == RSP_FETCH;
    assign bus.dma_rd_valid              = rsp_q == RSP_DMA;
    assign bus.instruction_in            = rsp_q == RSP_FETCH ? bus.mem_rd_data : 16'h0;
    assign bus.memory_in                 = rsp_q == RSP_DATA ? bus.mem_rd_data : 16'h0;
    assign bus.dma_rd_data               = rsp_q == RSP_DMA ? bus.mem_rd_data : 16'h0;
    assign bus.instruction_address_in    = iaddr_q;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state_q  <= ARB_CPU;
            burst_q  <= '0;
            starve_q <= '0;
            rsp_q    <= RSP_NONE;
            iaddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            starve_q <= starve_d;
            rsp_q    <= rsp_d;
            iaddr_q  <= iaddr_d;
        end
    end
endmodule
